// File: rtl/div_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : EXE-stage front end for the 33-cycle iterative 32-bit divider.
//            Issues one div/mod request at a time, holds the divider enable,
//            captures the selected result half and returns it over a
//            valid/ready handshake. Handles flush, divide-by-zero and a
//            completion watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_en,
  output logic             div_sign,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic [63:0]      div_result,
  input  logic             div_complete,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        y_q, y_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic               transfer;

  // Next-state and datapath capture; flush has priority over every other event.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    tag_d    = tag_q;
    data_d   = data_q;
    err_d    = err_q;
    wd_cnt_d = wd_cnt_q;
    transfer = req_valid & (state_q == S_IDLE) & ~flush;

    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          op_d     = req_op;
          x_d      = req_x;
          y_d      = req_y;
          tag_d    = req_tag;
          err_d    = 1'b0;
          wd_cnt_d = '0;
          if (req_y == 32'd0) begin
            // Divider is never started: quotient is 0, remainder is the dividend.
            data_d  = req_op[0] ? req_x : 32'd0;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (div_complete) begin
          data_d  = op_q[0] ? div_result[31:0] : div_result[63:32];
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th enable cycle with no completion.
          data_d  = 32'd0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (flush || resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      x_q      <= 32'd0;
      y_q      <= 32'd0;
      tag_q    <= '0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      err_q    <= err_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // All outputs come from registers, so divider signals never reach resp_* combinationally.
  assign req_ready  = (state_q == S_IDLE);
  assign div_en     = (state_q == S_BUSY);
  assign resp_valid = (state_q == S_DONE);
  assign div_sign   = ~op_q[1];
  assign div_x      = x_q;
  assign div_y      = y_q;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Purpose  : Scoreboard bench for div_issue_ctrl with a behavioural divider
//            stub and a high-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 63;

  logic             clk = 1'b0;
  logic             reset, flush, req_valid, req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_x, req_y;
  logic [TAG_W-1:0] req_tag;
  logic             div_en, div_sign, div_complete;
  logic [31:0]      div_x, div_y;
  logic [63:0]      div_result;
  logic             resp_valid, resp_ready, resp_err;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .div_en(div_en), .div_sign(div_sign), .div_x(div_x), .div_y(div_y),
    .div_result(div_result), .div_complete(div_complete),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err)
  );

  // Divider stub: completes after 33 enabled cycles, result valid while complete.
  logic [5:0] stub_cnt;
  bit         stub_hang = 1'b0;
  always @(posedge clk) begin
    if (reset || !div_en) stub_cnt <= 6'd0;
    else if (stub_cnt != 6'd63) stub_cnt <= stub_cnt + 6'd1;
  end
  assign div_complete = div_en && !stub_hang && (stub_cnt >= 6'd33);
  always_comb begin
    div_result = 64'hDEAD_BEEF_0BAD_F00D;
    if (div_complete && div_y != 32'd0) begin
      if (div_sign) div_result = {$signed(div_x) / $signed(div_y), $signed(div_x) % $signed(div_y)};
      else          div_result = {div_x / div_y, div_x % div_y};
    end
  end

  // Reference model: plain integer arithmetic from the request fields.
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] x, logic [31:0] y);
    int sx, sy;
    if (y == 32'd0) return op[0] ? x : 32'd0;
    if (!op[1]) begin
      sx = x; sy = y;
      return op[0] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return op[0] ? (x % y) : (x / y);
  endfunction

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int en_cycles = 0;
  bit hold_rr = 1'b1;
  bit rr_val  = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // resp_ready driver: random unless a test holds it.
  always @(posedge clk) begin
    #1;
    resp_ready = hold_rr ? rr_val : ($urandom_range(0, 3) != 0);
  end

  // Count enabled divider cycles.
  always @(negedge clk) if (div_en) en_cycles++;

  // Monitor: compare every response transfer with the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid && resp_ready && !flush) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_resp: got data 0x%08h tag %0d, expected no response", resp_data, resp_tag);
      end else begin
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_tag", 32'(resp_tag), 32'(e.tag));
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [31:0] x, logic [31:0] y, logic [TAG_W-1:0] tag,
                       logic [31:0] exp_data, logic exp_err);
    int w = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_tag = tag;
    @(negedge clk);
    while (!req_ready && w < 500) begin w++; @(negedge clk); end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 for 500 cycles expected 1");
    end else begin
      sb.push_back('{data: exp_data, tag: tag, err: exp_err});
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_x = $urandom; req_y = $urandom; req_op = 2'($urandom);
  endtask

  task automatic wait_valid(int bound);
    int w = 0;
    @(negedge clk);
    while (!resp_valid && w < bound) begin w++; @(negedge clk); end
    if (!resp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: got resp_valid 0 for %0d cycles expected 1", bound);
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || resp_valid) && w < 2000) begin w++; @(negedge clk); end
    if (sb.size() != 0 || resp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int en0, k, w, seen;
    logic [1:0]  rop;
    logic [31:0] rx, ry;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0;
    req_x = 32'd0; req_y = 32'd0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_div_en", 32'(div_en), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_div_x", div_x, 32'd0);
    check("rst_div_y", div_y, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    @(posedge clk); #1; reset = 1'b0; hold_rr = 1'b0;

    // Basic signed/unsigned results.
    issue(2'b00, 32'd7, 32'd2, 5'd1, 32'h0000_0003, 1'b0);
    issue(2'b01, 32'd7, 32'd2, 5'd2, 32'h0000_0001, 1'b0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0);
    issue(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'h7FFF_FFFF, 1'b0);
    drain();

    // Nominal enable window: 34 cycles.
    en0 = en_cycles;
    issue(2'b00, 32'd100, 32'd7, 5'd6, 32'd14, 1'b0);
    wait_valid(200);
    check("nominal_en_cycles", 32'(en_cycles - en0), 32'd34);
    drain();

    // Divide by zero: immediate response, divider never enabled.
    en0 = en_cycles;
    issue(2'b00, 32'h1234, 32'd0, 5'd7, 32'h0000_0000, 1'b0);
    @(negedge clk); check("div0_valid_next", 32'(resp_valid), 32'd1);
    drain();
    issue(2'b01, 32'h1234, 32'd0, 5'd8, 32'h0000_1234, 1'b0);
    @(negedge clk); check("mod0_valid_next", 32'(resp_valid), 32'd1);
    drain();
    issue(2'b11, 32'hABCD_0000, 32'd0, 5'd9, 32'hABCD_0000, 1'b0);
    drain();
    check("div0_no_en", 32'(en_cycles - en0), 32'd0);

    // Flush competing with an accept in IDLE: nothing is taken.
    @(posedge clk); #1; req_valid = 1'b1; flush = 1'b1; req_x = 32'd5; req_y = 32'd1;
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", 32'(req_ready), 32'd1);
    check("flush_idle_en", 32'(div_en), 32'd0);

    // Flush on the 10th BUSY cycle.
    issue(2'b00, 32'd1000, 32'd10, 5'd10, 32'd100, 1'b0);
    k = 0; w = 0;
    while (k < 10 && w < 100) begin @(negedge clk); if (div_en) k++; w++; end
    @(posedge clk); #1; flush = 1'b1; void'(sb.pop_back());
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_busy_en", 32'(div_en), 32'd0);
    check("flush_busy_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (resp_valid) seen++; end
    check("flush_no_resp", 32'(seen), 32'd0);
    issue(2'b00, 32'd1000, 32'd10, 5'd11, 32'd100, 1'b0);
    drain();

    // Back-pressure: response held stable for 20 cycles.
    hold_rr = 1'b1; rr_val = 1'b0;
    issue(2'b01, 32'hFFFF_FF9C, 32'd7, 5'd12, 32'hFFFF_FFFE, 1'b0);
    wait_valid(200);
    repeat (20) begin
      @(negedge clk);
      check("bp_data", resp_data, 32'hFFFF_FFFE);
      check("bp_tag", 32'(resp_tag), 32'd12);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(resp_valid), 32'd1);
    end
    rr_val = 1'b1;
    drain();

    // Flush beats a response transfer in DONE.
    rr_val = 1'b0;
    issue(2'b00, 32'd50, 32'd5, 5'd13, 32'd10, 1'b0);
    wait_valid(200);
    rr_val = 1'b1;
    @(posedge clk); #1; flush = 1'b1; void'(sb.pop_back());
    @(negedge clk); rr_val = 1'b0;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_done_valid", 32'(resp_valid), 32'd0);
    check("flush_done_ready", 32'(req_ready), 32'd1);
    hold_rr = 1'b0;

    // Watchdog: stub never completes.
    stub_hang = 1'b1;
    en0 = en_cycles;
    issue(2'b00, 32'd9, 32'd3, 5'd14, 32'd0, 1'b1);
    wait_valid(500);
    check("wd_en_cycles", 32'(en_cycles - en0), 32'(TIMEOUT));
    drain();
    stub_hang = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom);
      rx  = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 15);
        2:       ry = -32'($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      if (rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF) ry = 32'd3;
      issue(rop, rx, ry, TAG_W'($urandom), model(rop, rx, ry), 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
